shift_register_param: RTL and testbench
=======================================

# shift_register_param

Parametrised universal shift register with eight operating modes: hold, logical shift right/left, rotate right/left, arithmetic shift right, parallel load, and clear. A shift counter raises a frame-complete pulse after every WIDTH shift operations. It is the general serial/parallel conversion and bit-manipulation element for the miniproject datapath. The block drives serial links (serialiser/deserialiser) and acts as a scratch shifter.

## Interface
- WIDTH, 8, register width in bits; legal range 2..64.
- CW, $clog2(WIDTH+1), derived width of shift_count; not overridden.

- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset.
- en  input  1  clock enable; mode acts only when high.
- mode  input  3  operation select; encoding under Operation.
- serial_in  input  1  bit shifted in on logical shifts.
- parallel_in  input  WIDTH  load data for mode 101.
- parallel_output  output  WIDTH  register contents q.
- serial_out  output  1  registered copy of the bit that left q on the last shift/rotate.
- shift_count  output  CW  number of shifts since last load/clear/frame wrap, range 0..WIDTH-1.
- frame_done  output  1  one-cycle pulse, cycle after the WIDTH-th shift.

## Operation
- Mode encoding; each action applies on a clk edge with en=1:
  - 000 hold: q unchanged.
  - 001 SHR: q <= {serial_in, q[WIDTH-1:1]}; serial_out <= q[0].
  - 010 SHL: q <= {q[WIDTH-2:0], serial_in}; serial_out <= q[WIDTH-1].
  - 011 ROR: q <= {q[0], q[WIDTH-1:1]}; serial_out <= q[0].
  - 100 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}; serial_out <= q[WIDTH-1].
  - 101 LOAD: q <= parallel_in.
  - 110 ASR: q <= {q[WIDTH-1], q[WIDTH-1:1]}; serial_out <= q[0]; serial_in ignored.
  - 111 CLR: q <= 0.
- Modes 001, 010, 011, 100 and 110 are the shift operations. Only these update serial_out and increment shift_count.
- Counter:
  - LOAD and CLR set shift_count <= 0 and serial_out <= 0.
  - Shift with shift_count < WIDTH-1: shift_count increments.
  - Shift with shift_count == WIDTH-1: shift_count wraps to 0 and frame_done <= 1.
  - frame_done is 0 on every other edge, including edges with en=0.
- Hold, or en=0: q, serial_out and shift_count are unchanged.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Mixed shift directions all count toward the same frame. The counter does not track direction.

## Timing
- Reset (reset=0) is asynchronous and takes effect immediately:
  - parallel_output=0, serial_out=0, shift_count=0, frame_done=0.
  - Release is sampled at the first rising clk edge with reset=1. The block operates normally from that edge.
- Reset asserted mid-frame aborts the frame. No frame_done is produced for the aborted frame.
- Latency is one cycle for every mode. parallel_output reflects the op on the edge where en=1 was sampled.
- frame_done is high exactly one cycle, starting at the edge that performs the WIDTH-th shift.
- Back-to-back frames are supported with no gap: the next shift after a wrap counts as shift 1. frame_done can pulse every WIDTH cycles.
- A LOAD on the edge after the final shift does not suppress the already-registered frame_done pulse.
- An X/undefined mode value is not supported. Implementations treat any non-listed value as hold.

## Test plan
- Reset: hold reset=0 with clk running and random inputs.
  - Required: all outputs 0.
  - Deassert, then LOAD 0xA5 (WIDTH=8) -> parallel_output=0xA5 one edge later, shift_count=0.
- Logical shifts from 0xA5:
  - SHR, serial_in=1 -> 0xD2, serial_out=1.
  - Reload 0xA5; SHL, serial_in=0 -> 0x4A, serial_out=1.
- Rotate/arith:
  - Load 0x81: ROR -> 0xC0, then ROL -> 0x81.
  - Load 0x80: ASR twice -> 0xC0 then 0xE0, serial_out=0.
- Frame:
  - Load 0x00, then 8 consecutive SHR with serial_in=1.
  - Required: q=0xFF; shift_count walks 1..7 then 0; frame_done high only in the cycle after the 8th edge.
  - Continue with 8 more shifts -> second pulse exactly 8 cycles after the first.
- Enable/hold:
  - After 3 shifts, drop en for 5 cycles with mode=SHR -> q, shift_count=3 and serial_out frozen.
  - Mode 000 with en=1 -> same result.
- Abort:
  - After 5 shifts, pulse reset low mid-cycle -> outputs 0 immediately.
  - Then 8 shifts -> frame_done only after the 8th post-reset shift.
  - CLR at count 6 -> count 0 and no pulse.

Source files
------------

// File: rtl/shift_register_param.sv
// ---------------------------------------------------------------------------
// shift_register_param
//
// Universal WIDTH-bit shift register with eight modes: hold, logical shift
// right/left, rotate right/left, arithmetic shift right, parallel load and
// clear. Every shift-type operation advances a frame counter. After WIDTH
// shifts the counter wraps and frame_done pulses for one cycle.
//
// Ports:
//   clk             in   rising-edge clock
//   reset           in   asynchronous active-low reset
//   en              in   clock enable; the selected mode acts only when high
//   mode            in   [2:0] operation select (see localparams below)
//   serial_in       in   bit shifted in by SHR / SHL
//   parallel_in     in   [WIDTH-1:0] data for LOAD
//   parallel_output out  [WIDTH-1:0] register contents
//   serial_out      out  registered copy of the bit that left on the last shift
//   shift_count     out  [CW-1:0] shifts since last load/clear/wrap
//   frame_done      out  one-cycle pulse after the WIDTH-th shift
// ---------------------------------------------------------------------------
module shift_register_param #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] parallel_in,
  output logic [WIDTH-1:0] parallel_output,
  output logic             serial_out,
  output logic [CW-1:0]    shift_count,
  output logic             frame_done
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_ROR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_LOAD = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_reg, q_next;
  logic             serial_out_reg, serial_out_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             frame_done_reg, frame_done_next;
  logic             is_shift;

  always_comb begin
    q_next          = q_reg;
    serial_out_next = serial_out_reg;
    count_next      = count_reg;
    frame_done_next = 1'b0;   // pulse: low on every edge unless a frame wraps
    is_shift        = 1'b0;

    if (en) begin
      case (mode)
        MODE_HOLD: begin
        end
        MODE_SHR: begin
          q_next          = {serial_in, q_reg[WIDTH-1:1]};
          serial_out_next = q_reg[0];
          is_shift        = 1'b1;
        end
        MODE_SHL: begin
          q_next          = {q_reg[WIDTH-2:0], serial_in};
          serial_out_next = q_reg[WIDTH-1];
          is_shift        = 1'b1;
        end
        MODE_ROR: begin
          q_next          = {q_reg[0], q_reg[WIDTH-1:1]};
          serial_out_next = q_reg[0];
          is_shift        = 1'b1;
        end
        MODE_ROL: begin
          q_next          = {q_reg[WIDTH-2:0], q_reg[WIDTH-1]};
          serial_out_next = q_reg[WIDTH-1];
          is_shift        = 1'b1;
        end
        MODE_LOAD: begin
          q_next          = parallel_in;
          serial_out_next = 1'b0;
          count_next      = '0;
        end
        MODE_ASR: begin
          q_next          = {q_reg[WIDTH-1], q_reg[WIDTH-1:1]};
          serial_out_next = q_reg[0];
          is_shift        = 1'b1;
        end
        MODE_CLR: begin
          q_next          = '0;
          serial_out_next = 1'b0;
          count_next      = '0;
        end
        default: begin
          // Undefined encodings behave as hold.
        end
      endcase
    end

    // All shift directions share one frame counter.
    if (is_shift) begin
      if (count_reg == LAST_COUNT) begin
        count_next      = '0;
        frame_done_next = 1'b1;
      end else begin
        count_next = count_reg + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_reg          <= '0;
      serial_out_reg <= 1'b0;
      count_reg      <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      q_reg          <= q_next;
      serial_out_reg <= serial_out_next;
      count_reg      <= count_next;
      frame_done_reg <= frame_done_next;
    end
  end

  assign parallel_output = q_reg;
  assign serial_out      = serial_out_reg;
  assign shift_count     = count_reg;
  assign frame_done      = frame_done_reg;

endmodule

// File: tb/tb_shift_register_param.sv
// ---------------------------------------------------------------------------
// tb_shift_register_param
//
// Directed-vector bench for shift_register_param (WIDTH=8). Expected values
// are hand-computed constants; every comparison goes through task check.
// ---------------------------------------------------------------------------
module tb_shift_register_param;

  localparam int WIDTH = 8;
  localparam int CW    = $clog2(WIDTH + 1);

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_SHR  = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_ROR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_LOAD = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  logic             clk;
  logic             reset;
  logic             en;
  logic [2:0]       mode;
  logic             serial_in;
  logic [WIDTH-1:0] parallel_in;
  logic [WIDTH-1:0] parallel_output;
  logic             serial_out;
  logic [CW-1:0]    shift_count;
  logic             frame_done;

  int checks;
  int errors;

  shift_register_param #(.WIDTH(WIDTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .en              (en),
    .mode            (mode),
    .serial_in       (serial_in),
    .parallel_in     (parallel_in),
    .parallel_output (parallel_output),
    .serial_out      (serial_out),
    .shift_count     (shift_count),
    .frame_done      (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare all four outputs against expected values.
  task automatic expect_all(input string tag, input logic [WIDTH-1:0] q, input logic so,
                            input logic [CW-1:0] cnt, input logic fd);
    check({tag, ".q"},   64'(parallel_output), 64'(q));
    check({tag, ".so"},  64'(serial_out),      64'(so));
    check({tag, ".cnt"}, 64'(shift_count),     64'(cnt));
    check({tag, ".fd"},  64'(frame_done),      64'(fd));
  endtask

  // One transaction: drive inputs, take one rising edge, settle 1 time unit.
  task automatic op(input logic e, input logic [2:0] m, input logic si, input logic [WIDTH-1:0] pin);
    en          = e;
    mode        = m;
    serial_in   = si;
    parallel_in = pin;
    @(posedge clk);
    #1;
    $display("t=%0t en=%0b mode=%0d si=%0b pin=%02h -> q=%02h so=%0b cnt=%0d fd=%0b",
             $time, e, m, si, pin, parallel_output, serial_out, shift_count, frame_done);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b0;
    en          = 1'b0;
    mode        = M_HOLD;
    serial_in   = 1'b0;
    parallel_in = '0;

    // Reset held with random activity on the inputs.
    for (int i = 0; i < 3; i++) begin
      en          = 1'($urandom_range(0, 1));
      mode        = 3'($urandom_range(0, 7));
      serial_in   = 1'($urandom_range(0, 1));
      parallel_in = WIDTH'($urandom);
      @(posedge clk);
      #1;
      expect_all("reset", 8'h00, 1'b0, 4'd0, 1'b0);
    end
    reset = 1'b1;

    // Load and logical shifts.
    op(1'b1, M_LOAD, 1'b0, 8'hA5);  expect_all("load_a5", 8'hA5, 1'b0, 4'd0, 1'b0);
    op(1'b1, M_SHR,  1'b1, 8'h00);  expect_all("shr",     8'hD2, 1'b1, 4'd1, 1'b0);
    op(1'b1, M_LOAD, 1'b0, 8'hA5);  expect_all("reload",  8'hA5, 1'b0, 4'd0, 1'b0);
    op(1'b1, M_SHL,  1'b0, 8'h00);  expect_all("shl",     8'h4A, 1'b1, 4'd1, 1'b0);

    // Rotates and arithmetic shift.
    op(1'b1, M_LOAD, 1'b0, 8'h81);  expect_all("load_81", 8'h81, 1'b0, 4'd0, 1'b0);
    op(1'b1, M_ROR,  1'b0, 8'h00);  expect_all("ror",     8'hC0, 1'b1, 4'd1, 1'b0);
    op(1'b1, M_ROL,  1'b0, 8'h00);  expect_all("rol",     8'h81, 1'b1, 4'd2, 1'b0);
    op(1'b1, M_LOAD, 1'b0, 8'h80);  expect_all("load_80", 8'h80, 1'b0, 4'd0, 1'b0);
    op(1'b1, M_ASR,  1'b1, 8'h00);  expect_all("asr1",    8'hC0, 1'b0, 4'd1, 1'b0);
    op(1'b1, M_ASR,  1'b1, 8'h00);  expect_all("asr2",    8'hE0, 1'b0, 4'd2, 1'b0);

    // Frame: 8 SHR of ones from zero; pulse only after the 8th.
    op(1'b1, M_LOAD, 1'b0, 8'h00);  expect_all("load_00", 8'h00, 1'b0, 4'd0, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      op(1'b1, M_SHR, 1'b1, 8'h00);
      check($sformatf("frame1.cnt%0d", k), 64'(shift_count), 64'(k % 8));
      check($sformatf("frame1.fd%0d", k),  64'(frame_done),  64'(k == 8));
    end
    check("frame1.q", 64'(parallel_output), 64'hFF);
    // Second frame back-to-back: pulse exactly 8 cycles later.
    for (int k = 1; k <= 8; k++) begin
      op(1'b1, M_SHR, 1'b1, 8'h00);
      check($sformatf("frame2.cnt%0d", k), 64'(shift_count), 64'(k % 8));
      check($sformatf("frame2.fd%0d", k),  64'(frame_done),  64'(k == 8));
    end
    // LOAD right after the final shift; the pulse seen above was not suppressed.
    op(1'b1, M_LOAD, 1'b0, 8'h3C);  expect_all("load_3c", 8'h3C, 1'b0, 4'd0, 1'b0);

    // Enable/hold: 3 shifts then freeze.
    op(1'b1, M_SHR, 1'b0, 8'h00);   expect_all("eh_s1", 8'h1E, 1'b0, 4'd1, 1'b0);
    op(1'b1, M_SHR, 1'b0, 8'h00);   expect_all("eh_s2", 8'h0F, 1'b0, 4'd2, 1'b0);
    op(1'b1, M_SHR, 1'b0, 8'h00);   expect_all("eh_s3", 8'h07, 1'b1, 4'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      op(1'b0, M_SHR, 1'b1, 8'hFF);
      expect_all($sformatf("en_off%0d", i), 8'h07, 1'b1, 4'd3, 1'b0);
    end
    for (int i = 0; i < 2; i++) begin
      op(1'b1, M_HOLD, 1'b1, 8'hFF);
      expect_all($sformatf("hold%0d", i), 8'h07, 1'b1, 4'd3, 1'b0);
    end

    // Abort: reset mid-cycle after 5 shifts.
    op(1'b1, M_LOAD, 1'b0, 8'h00);
    for (int k = 1; k <= 5; k++) op(1'b1, M_SHR, 1'b1, 8'h00);
    expect_all("pre_abort", 8'hF8, 1'b0, 4'd5, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    expect_all("abort_now", 8'h00, 1'b0, 4'd0, 1'b0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      op(1'b1, M_SHR, 1'b0, 8'h00);
      check($sformatf("post_rst.cnt%0d", k), 64'(shift_count), 64'(k % 8));
      check($sformatf("post_rst.fd%0d", k),  64'(frame_done),  64'(k == 8));
    end

    // CLR at count 6 cancels the frame.
    for (int k = 1; k <= 6; k++) op(1'b1, M_SHL, 1'b1, 8'h00);
    expect_all("pre_clr", 8'h3F, 1'b0, 4'd6, 1'b0);
    op(1'b1, M_CLR, 1'b1, 8'hFF);   expect_all("clr", 8'h00, 1'b0, 4'd0, 1'b0);
    op(1'b1, M_ROL, 1'b0, 8'h00);   expect_all("after_clr1", 8'h00, 1'b0, 4'd1, 1'b0);
    op(1'b1, M_ROL, 1'b0, 8'h00);   expect_all("after_clr2", 8'h00, 1'b0, 4'd2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
